// File: rtl/led_bar_pkg.sv
// ---------------------------------------------------------------------------
// led_bar_pkg
// Shared types and helpers for the LED bar controller.
//   mode_e    : display mode encoding (all four 2-bit codes are legal)
//   LED_ON/OFF: active-low LED drive levels
//   bar_mask  : n ones from the LSB, clipped to width
// ---------------------------------------------------------------------------
package led_bar_pkg;

    typedef enum logic [1:0] {
        MODE_BAR   = 2'd0,
        MODE_CHASE = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_FILL  = 2'd3
    } mode_e;

    localparam logic LED_ON  = 1'b0;
    localparam logic LED_OFF = 1'b1;

    // Widest bar the mask helper can describe; callers truncate to LED_W.
    localparam int unsigned MAX_LED_W = 64;

    function automatic logic [MAX_LED_W-1:0] bar_mask(input int unsigned n,
                                                      input int unsigned width);
        logic [MAX_LED_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_LED_W; i++) begin
            if ((i < n) && (i < width)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/led_bar_ctrl_sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
// Two-flop synchroniser plus stable-sample counter for a switch bank.
// Ports:
//   clk, rst (async, active-high)
//   sw_in  [W-1:0] raw asynchronous switch pins
//   sw_db  [W-1:0] debounced switch vector
//   db_vld         set once the first debounced vector has been accepted
// ---------------------------------------------------------------------------
module sw_debounce
    import led_bar_pkg::*;
#(
    parameter int W            = 4,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sw_in,
    output logic [W-1:0] sw_db,
    output logic         db_vld
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [W-1:0]  sync1_q, sync1_d;
    logic [W-1:0]  sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sw_db_q, sw_db_d;
    logic          vld_q, vld_d;

    // cnt_q = number of consecutive clocks sync2_q has held its value,
    // saturating at DEBOUNCE_CYC. A change is seen one cycle early as
    // sync1_q != sync2_q, so the new value starts at a count of 1.
    always_comb begin
        sync1_d = sw_in;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        sw_db_d = sw_db_q;
        vld_d   = vld_q;

        if (cnt_q == CW'(DEBOUNCE_CYC)) begin
            sw_db_d = sync2_q;
            vld_d   = 1'b1;
        end

        if (sync1_q != sync2_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q != CW'(DEBOUNCE_CYC)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            sw_db_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            sw_db_q <= sw_db_d;
            vld_q   <= vld_d;
        end
    end

    assign sw_db  = sw_db_q;
    // The reset value of sw_db (all zero) decodes as a lit, non-blank bar,
    // so the top keeps the bar dark until a real vector has been accepted.
    assign db_vld = vld_q;

endmodule

// File: rtl/led_bar_ctrl.sv
// ---------------------------------------------------------------------------
// led_bar_ctrl
// Switch-driven active-low LED bar: BAR, CHASE, BLINK and FILL patterns.
// Optional feature macro: LED_PWM_EN (adds 4-bit PWM brightness on 'duty').
// Ports:
//   clk            system clock
//   rst            asynchronous reset, active-high
//   switch [SW_W]  raw switch pins; bit0 = blank, [SW_W-1:1] = level
//   mode   [2]     0 BAR, 1 CHASE, 2 BLINK, 3 FILL (used as-is)
//   led    [LED_W] registered LED drive, 0 = LED on
//   duty   [4]     PWM duty, only with LED_PWM_EN
// ---------------------------------------------------------------------------
module led_bar_ctrl
    import led_bar_pkg::*;
#(
    parameter int LED_W        = 8,
    parameter int SW_W         = 4,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int STEP_CYC     = 5000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SW_W-1:0]  switch,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] led
`ifdef LED_PWM_EN
    ,
    input  logic [3:0]       duty
`endif
);

    localparam int CNT_W = $clog2(LED_W + 1);
    localparam int POS_W = $clog2(LED_W);
    localparam int TMR_W = $clog2(STEP_CYC);

    logic [SW_W-1:0]  sw_db;
    logic             db_vld;
    logic [SW_W-2:0]  level;
    logic [CNT_W-1:0] n;
    logic [LED_W-1:0] bar;
    logic [LED_W-1:0] lit;
    logic             blank;
    logic             restart;
    logic             tick;
    logic             gate;

    mode_e            state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] fill_q, fill_d;   // holds f-1, so f runs 1..n
    logic             phase_q, phase_d;
    logic [LED_W-1:0] led_q, led_d;
`ifdef LED_PWM_EN
    logic [3:0]       pwm_cnt_q, pwm_cnt_d;
`endif

    sw_debounce #(
        .W            (SW_W),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_sw_debounce (
        .clk    (clk),
        .rst    (rst),
        .sw_in  (switch),
        .sw_db  (sw_db),
        .db_vld (db_vld)
    );

    // Lit count: level + 1, saturating at LED_W.
    always_comb begin
        level = sw_db[SW_W-1:1];
        if (32'(level) >= 32'(LED_W - 1)) begin
            n = CNT_W'(LED_W);
        end else begin
            n = CNT_W'(level) + CNT_W'(1);
        end
        bar = LED_W'(bar_mask(32'(n), LED_W));
    end

    always_comb begin
        state_d = mode_e'(mode);
        n_d     = n;
        timer_d = timer_q;
        pos_d   = pos_q;
        fill_d  = fill_q;
        phase_d = phase_q;
        tick    = 1'b0;
        lit     = '0;
        led_d   = '1;
        gate    = 1'b1;
`ifdef LED_PWM_EN
        pwm_cnt_d = pwm_cnt_q + 4'd1;
        gate      = (pwm_cnt_q < duty);
`endif

        blank   = !db_vld || sw_db[0];
        // A new mode or lit count restarts the animation from its origin.
        restart = (state_d != state_q) || (n != n_q);

        if (blank || restart) begin
            timer_d = '0;
            pos_d   = '0;
            fill_d  = '0;
            phase_d = 1'b1;
        end else begin
            if (timer_q == TMR_W'(STEP_CYC - 1)) begin
                tick    = 1'b1;
                timer_d = '0;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end

            if (tick) begin
                pos_d   = (pos_q == POS_W'(LED_W - 1)) ? '0 : pos_q + POS_W'(1);
                phase_d = !phase_q;
                fill_d  = ((fill_q + CNT_W'(1)) >= n) ? '0 : fill_q + CNT_W'(1);
            end
        end

        // Pattern is built from the next-state values so the register
        // shows the new step on the same edge that takes it.
        case (state_d)
            MODE_BAR:   lit = bar;
            // Rotate left by pos_d: upper half of the doubled bar after shifting.
            MODE_CHASE: lit = LED_W'(({bar, bar} << pos_d) >> LED_W);
            MODE_BLINK: lit = phase_d ? bar : '0;
            MODE_FILL:  lit = LED_W'(bar_mask(32'(fill_d) + 1, LED_W));
            default:    lit = bar;
        endcase

        if (blank) begin
            lit = '0;
        end

        for (int i = 0; i < LED_W; i++) begin
            led_d[i] = (lit[i] && gate) ? LED_ON : LED_OFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MODE_BAR;
            n_q     <= '0;
            timer_q <= '0;
            pos_q   <= '0;
            fill_q  <= '0;
            phase_q <= 1'b1;
            led_q   <= '1;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            timer_q <= timer_d;
            pos_q   <= pos_d;
            fill_q  <= fill_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

`ifdef LED_PWM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end
`endif

    assign led = led_q;

endmodule

// File: tb/tb_led_bar_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_bar_ctrl
// Scoreboard bench for led_bar_ctrl (LED_W=8, SW_W=4, DEBOUNCE_CYC=4,
// STEP_CYC=8). Stimulus pushes (cycle, expected led) entries; a monitor on
// the falling edge compares every entry that falls due.
// With LED_PWM_EN defined, the duty port and the PWM section are included.
// ---------------------------------------------------------------------------
module tb_led_bar_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] switch;
    logic [1:0] mode;
    logic [7:0] led;
    logic [3:0] duty_v;
`ifdef LED_PWM_EN
    logic [3:0] duty;
`endif

    typedef struct {
        int           cyc;
        logic [7:0]   val;
        logic [3:0]   duty;
        logic [127:0] nm;
    } exp_t;

    exp_t sb[$];

    int         cyc;
    int         r_cyc;
    int         n_chk;
    int         n_pass;
    int         async_seq;
    int         async_seen;
    logic [7:0] async_led;
    logic       flush;

    logic [7:0] chase_tbl [9];

    led_bar_ctrl #(
        .LED_W        (8),
        .SW_W         (4),
        .DEBOUNCE_CYC (4),
        .STEP_CYC     (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .switch (switch),
        .mode   (mode),
        .led    (led)
`ifdef LED_PWM_EN
        ,
        .duty   (duty)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef LED_PWM_EN
    // Lit bits are driven only while the free-running counter is below duty;
    // the counter value used at an edge is (edges since release - 1) mod 16.
    function automatic logic [7:0] pwm_model(input logic [7:0] v, input int c,
                                             input logic [3:0] d);
        int k;
        k = c - r_cyc;
        if (k >= 1 && (((k - 1) % 16) >= int'(d))) return 8'hFF;
        return v;
    endfunction
`endif

    // Monitor: compares due scoreboard entries and the async-reset sample.
    initial begin
        n_chk      = 0;
        n_pass     = 0;
        async_seen = 0;
        forever begin
            @(negedge clk);
            if (async_seq != async_seen) begin
                async_seen = async_seq;
                n_chk++;
                if (async_led === 8'hFF) n_pass++;
                else $display("FAIL async_reset: led=%h required ff", async_led);
            end
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc || flush) begin
                    logic [7:0] ev;
`ifdef LED_PWM_EN
                    ev = pwm_model(sb[i].val, sb[i].cyc, sb[i].duty);
`else
                    ev = sb[i].val;
`endif
                    n_chk++;
                    if (sb[i].cyc == cyc && led === ev) n_pass++;
                    else $display("FAIL %0s: led=%h required %h (cycle %0d, now %0d)",
                                  sb[i].nm, led, ev, sb[i].cyc, cyc);
                    sb.delete(i);
                end
            end
        end
    end

    task automatic push(input int dc, input logic [7:0] v, input logic [127:0] nm);
        exp_t e;
        e.cyc  = cyc + dc;
        e.val  = v;
        e.duty = duty_v;
        e.nm   = nm;
        sb.push_back(e);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_in(input logic [3:0] sw, input logic [1:0] md);
        switch = sw;
        mode   = md;
    endtask

    initial begin
        chase_tbl = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
        rst       = 1'b1;
        switch    = 4'b0001;
        mode      = 2'd0;
        duty_v    = 4'd15;
`ifdef LED_PWM_EN
        duty      = duty_v;
`endif
        r_cyc     = 0;
        async_seq = 0;
        async_led = 8'h00;
        flush     = 1'b0;

        // Reset and blank start-up
        wait_n(3);
        push(1, 8'hFF, "reset_dark");
        wait_n(1);
        rst   = 1'b0;
        r_cyc = cyc;
        push(1,  8'hFF, "post_rst");
        push(12, 8'hFF, "blank_hold");
        wait_n(14);

        // BAR levels and latency
        set_in(4'b0110, 2'd0);
        push(6, 8'hFF, "bar_lat6");
        push(7, 8'hF0, "bar_lat7");
        wait_n(10);
        set_in(4'b1110, 2'd0);
        push(6, 8'hF0, "bar_full_pre");
        push(7, 8'h00, "bar_full");
        wait_n(10);
        set_in(4'b0111, 2'd0);
        push(7, 8'hFF, "bar_blank");
        wait_n(10);
        set_in(4'b0110, 2'd0);
        push(7, 8'hF0, "bar_unblank");
        wait_n(10);

        // Debounce glitch rejection (3 cycles) and acceptance (4 cycles)
        push(7,  8'hF0, "glitch3_a");
        push(10, 8'hF0, "glitch3_b");
        switch = 4'b0100;
        wait_n(3);
        switch = 4'b0110;
        wait_n(12);
        push(6,  8'hF0, "hold4_pre");
        push(7,  8'hF8, "hold4_acc");
        push(10, 8'hF8, "hold4_held");
        push(11, 8'hF0, "hold4_back");
        switch = 4'b0100;
        wait_n(4);
        switch = 4'b0110;
        wait_n(12);

        // CHASE at level 0, then level 1 mid-run
        set_in(4'b0000, 2'd1);
        push(1,  8'hF0, "chase_mode");
        push(14, 8'hFE, "chase_hold");
        for (int k = 0; k < 9; k++) push(7 + 8 * k, chase_tbl[k], "chase_step");
        wait_n(74);
        switch = 4'b0010;
        push(7,  8'hFC, "chase_lvl1");
        push(14, 8'hFC, "chase_lvl1_hold");
        push(15, 8'hF9, "chase_lvl1_step");
        wait_n(18);

        // Asynchronous reset mid-animation
        #2;
        rst = 1'b1;
        #1;
        async_led = led;
        async_seq = async_seq + 1;
        wait_n(1);
        rst   = 1'b0;
        r_cyc = cyc;
        push(1,  8'hFF, "rst_release");
        push(6,  8'hFF, "rst_dark_wait");
        push(7,  8'hFC, "rst_restart");
        push(15, 8'hF9, "rst_step");
        wait_n(20);

        // BLINK at level 2, then FILL
        set_in(4'b0100, 2'd2);
        push(1,  8'hFC, "blink_start");
        push(7,  8'hF8, "blink_on");
        push(14, 8'hF8, "blink_on_hold");
        push(15, 8'hFF, "blink_off");
        push(22, 8'hFF, "blink_off_hold");
        push(23, 8'hF8, "blink_on2");
        wait_n(26);
        mode = 2'd3;
        push(1,  8'hFE, "fill_1");
        push(8,  8'hFE, "fill_1_hold");
        push(9,  8'hFC, "fill_2");
        push(17, 8'hF8, "fill_3");
        push(25, 8'hFE, "fill_wrap");
        wait_n(27);

`ifdef LED_PWM_EN
        // PWM brightness at level 0
        set_in(4'b0000, 2'd0);
        push(7, 8'hFE, "pwm_bar");
        wait_n(10);
        duty_v = 4'd4;
        duty   = duty_v;
        for (int j = 1; j <= 32; j++) push(j, 8'hFE, "pwm_duty4");
        wait_n(34);
        duty_v = 4'd0;
        duty   = duty_v;
        for (int j = 1; j <= 16; j++) push(j, 8'hFE, "pwm_duty0");
        wait_n(18);
`endif

        // Drain, bounded; anything left over is reported by the monitor.
        for (int i = 0; i < 100 && sb.size() > 0; i++) wait_n(1);
        flush = 1'b1;
        wait_n(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
